// File: rtl/mem_subsystem_if.sv
// mem_subsystem_if: one request/response port of the memory subsystem.
//   valid/ready         request handshake (accepted on valid & ready)
//   addr                byte address
//   we                  1 = store, 0 = load
//   size                00 byte, 01 half, 10 word, 11 illegal
//   is_unsigned         loads: 1 zero-extend, 0 sign-extend
//   wdata               store data, right-aligned
//   rvalid/rdata/err    single-cycle response; err marks a rejected request
// master = requester (control unit / bench), slave = memory subsystem.
interface mem_subsystem_if #(
   parameter int ADDR_W = 12,
   parameter int WORD_W = 32
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [1:0]        size;
   logic              is_unsigned;
   logic [WORD_W-1:0] wdata;
   logic              rvalid;
   logic [WORD_W-1:0] rdata;
   logic              err;

   modport master (output valid, addr, we, size, is_unsigned, wdata,
                   input  ready, rvalid, rdata, err);
   modport slave  (input  valid, addr, we, size, is_unsigned, wdata,
                   output ready, rvalid, rdata, err);
endinterface

// File: rtl/mem_subsystem.sv
// mem_subsystem: unified instruction+data RAM with two independent ports,
// byte/half/word access with sign/zero extension, alignment/range checks,
// 1- or 2-cycle read latency, optional post-reset RAM clear, plus PC and
// previous-PC registers.
//   clk, rst              clock; asynchronous active-high reset
//   p1, p2                request/response ports (mem_subsystem_if.slave)
//   pc_WE, pc_in          load program counter
//   old_pc_WE             copy pc_out into old_pc_out
//   pc_out, old_pc_out    program counter and previous PC
module mem_subsystem #(
   parameter int                 WORD_W        = 32,
   parameter int                 INSTR_WORDS   = 256,
   parameter int                 DATA_WORDS    = 768,
   parameter int                 ADDR_W        = 12,
   parameter int                 READ_LAT      = 1,
   parameter bit                 IMEM_WRITABLE = 1'b0,
   parameter bit                 CLEAR_ON_RST  = 1'b1,
   parameter logic [WORD_W-1:0]  RESET_PC      = '0
) (
   input  logic              clk,
   input  logic              rst,
   mem_subsystem_if.slave    p1,
   mem_subsystem_if.slave    p2,
   input  logic              pc_WE,
   input  logic [WORD_W-1:0] pc_in,
   input  logic              old_pc_WE,
   output logic [WORD_W-1:0] pc_out,
   output logic [WORD_W-1:0] old_pc_out
);
   localparam int DEPTH = INSTR_WORDS + DATA_WORDS;
   localparam int NB    = WORD_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {CLEAR, RUN} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  clr_q, clr_d;
   logic              ready_q;
   logic [WORD_W-1:0] mem [DEPTH];

   function automatic logic req_err(input logic [ADDR_W-1:0] a,
                                    input logic [1:0] sz, input logic we);
      logic [31:0] w;
      w = 32'(a[ADDR_W-1:2]);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
             (sz == 2'b10 && a[1:0] != 2'b00) || (w >= DEPTH) ||
             (we && !IMEM_WRITABLE && w < INSTR_WORDS);
   endfunction

   function automatic logic [NB-1:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
      case (sz)
         2'b00:   return NB'(1) << lane;
         2'b01:   return NB'(3) << lane;
         default: return '1;
      endcase
   endfunction

   // Small stores are replicated across all lanes; the byte enables pick the lane.
   function automatic logic [WORD_W-1:0] lane_data(input logic [1:0] sz, input logic [WORD_W-1:0] d);
      case (sz)
         2'b00:   return {NB{d[7:0]}};
         2'b01:   return {(NB/2){d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] load_ext(input logic [WORD_W-1:0] w, input logic [1:0] sz,
                                                  input logic [1:0] lane, input logic uns);
      logic [WORD_W-1:0] s;
      s = w >> {lane, 3'b000};
      case (sz)
         2'b00:   return uns ? WORD_W'(s[7:0])  : {{(WORD_W-8){s[7]}}, s[7:0]};
         2'b01:   return uns ? WORD_W'(s[15:0]) : {{(WORD_W-16){s[15]}}, s[15:0]};
         default: return s;
      endcase
   endfunction

   // Request decode
   logic             acc1, acc2, err1, err2;
   logic [IDX_W-1:0] idx1, idx2;
   logic [NB-1:0]    be1, be2;
   logic [WORD_W-1:0] wd1, wd2, rd1, rd2;

   assign p1.ready = ready_q;
   assign p2.ready = ready_q;
   assign acc1 = p1.valid & ready_q;
   assign acc2 = p2.valid & ready_q;
   assign err1 = req_err(p1.addr, p1.size, p1.we);
   assign err2 = req_err(p2.addr, p2.size, p2.we);
   assign idx1 = p1.addr[IDX_W+1:2];
   assign idx2 = p2.addr[IDX_W+1:2];
   assign be1  = (acc1 & p1.we & ~err1) ? byte_en(p1.size, p1.addr[1:0]) : '0;
   assign be2  = (acc2 & p2.we & ~err2) ? byte_en(p2.size, p2.addr[1:0]) : '0;
   assign wd1  = lane_data(p1.size, p1.wdata);
   assign wd2  = lane_data(p2.size, p2.wdata);
   // Combinational read of the pre-edge array gives read-first behaviour.
   assign rd1  = (acc1 & ~p1.we & ~err1) ? load_ext(mem[idx1], p1.size, p1.addr[1:0], p1.is_unsigned) : '0;
   assign rd2  = (acc2 & ~p2.we & ~err2) ? load_ext(mem[idx2], p2.size, p2.addr[1:0], p2.is_unsigned) : '0;

   // RAM: not reset. Port 2 is written last so it wins overlapping byte lanes.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[clr_q] <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (be1[b]) mem[idx1][8*b +: 8] <= wd1[8*b +: 8];
            if (be2[b]) mem[idx2][8*b +: 8] <= wd2[8*b +: 8];
         end
      end
   end

   // Clear sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR_ON_RST ? CLEAR : RUN;
         clr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         ready_q <= (state_d == RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      case (state_q)
         CLEAR: begin
            clr_d = clr_q + IDX_W'(1);
            if (clr_q == IDX_W'(DEPTH - 1)) begin
               state_d = RUN;
               clr_d   = '0;
            end
         end
         default: ;
      endcase
   end

   // Stage p1: registered response
   logic [1:0]             vld_p1_q, err_p1_q;
   logic [1:0][WORD_W-1:0] dat_p1_q;
   logic [1:0]             vld_out, err_out;
   logic [1:0][WORD_W-1:0] dat_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= '0;
         err_p1_q <= '0;
         dat_p1_q <= '0;
      end else begin
         vld_p1_q <= {acc2, acc1};
         err_p1_q <= {acc2 & err2, acc1 & err1};
         dat_p1_q <= {rd2, rd1};
      end
   end

   // Stage p2: optional extra output register
   generate
      if (READ_LAT == 2) begin : g_lat2
         logic [1:0]             vld_p2_q, err_p2_q;
         logic [1:0][WORD_W-1:0] dat_p2_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_p2_q <= '0;
               err_p2_q <= '0;
               dat_p2_q <= '0;
            end else begin
               vld_p2_q <= vld_p1_q;
               err_p2_q <= err_p1_q;
               dat_p2_q <= dat_p1_q;
            end
         end
         assign vld_out = vld_p2_q;
         assign err_out = err_p2_q;
         assign dat_out = dat_p2_q;
      end else begin : g_lat1
         assign vld_out = vld_p1_q;
         assign err_out = err_p1_q;
         assign dat_out = dat_p1_q;
      end
   endgenerate

   assign p1.rvalid = vld_out[0];
   assign p1.err    = err_out[0];
   assign p1.rdata  = dat_out[0];
   assign p2.rvalid = vld_out[1];
   assign p2.err    = err_out[1];
   assign p2.rdata  = dat_out[1];

   // PC registers; old_pc captures the pre-update pc_out.
   logic [WORD_W-1:0] pc_q, old_pc_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         old_pc_q <= '0;
      end else begin
         if (pc_WE)     pc_q     <= pc_in;
         if (old_pc_WE) old_pc_q <= pc_q;
      end
   end
   assign pc_out     = pc_q;
   assign old_pc_out = old_pc_q;
endmodule

// File: tb/tb_mem_subsystem.sv
// Directed bench for mem_subsystem. u_dut1: READ_LAT=1, clear on reset,
// 13-bit address so out-of-range words are reachable. u_dut2: READ_LAT=2,
// no clear, used for pipelining and mid-burst reset.
module tb_mem_subsystem;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst2;
   logic        pc_we, old_we, pc_we2, old_we2;
   logic [31:0] pc_in, pc_out, old_pc_out, pc_in2, pc_out2, old_pc_out2;
   int checks = 0;
   int errors = 0;

   mem_subsystem_if #(.ADDR_W(13), .WORD_W(32)) a1 ();
   mem_subsystem_if #(.ADDR_W(13), .WORD_W(32)) a2 ();
   mem_subsystem_if #(.ADDR_W(12), .WORD_W(32)) b1 ();
   mem_subsystem_if #(.ADDR_W(12), .WORD_W(32)) b2 ();

   mem_subsystem #(.ADDR_W(13), .READ_LAT(1), .CLEAR_ON_RST(1'b1), .RESET_PC(32'h100)) u_dut1 (
      .clk(clk), .rst(rst1), .p1(a1), .p2(a2), .pc_WE(pc_we), .pc_in(pc_in),
      .old_pc_WE(old_we), .pc_out(pc_out), .old_pc_out(old_pc_out));

   mem_subsystem #(.ADDR_W(12), .READ_LAT(2), .CLEAR_ON_RST(1'b0)) u_dut2 (
      .clk(clk), .rst(rst2), .p1(b1), .p2(b2), .pc_WE(pc_we2), .pc_in(pc_in2),
      .old_pc_WE(old_we2), .pc_out(pc_out2), .old_pc_out(old_pc_out2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv1(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [12:0] ad, input logic [31:0] wd);
      a1.valid = v; a1.we = we; a1.size = sz; a1.is_unsigned = uns; a1.addr = ad; a1.wdata = wd;
   endtask

   task automatic drv2(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [12:0] ad, input logic [31:0] wd);
      a2.valid = v; a2.we = we; a2.size = sz; a2.is_unsigned = uns; a2.addr = ad; a2.wdata = wd;
   endtask

   task automatic drvb(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [11:0] ad, input logic [31:0] wd);
      b1.valid = v; b1.we = we; b1.size = sz; b1.is_unsigned = uns; b1.addr = ad; b1.wdata = wd;
   endtask

   task automatic test_reset();
      int cnt;
      rst1 = 1'b1; rst2 = 1'b1;
      drv1(0, 0, 0, 0, 0, 0); drv2(0, 0, 0, 0, 0, 0); drvb(0, 0, 0, 0, 0, 0);
      b2.valid = 0; b2.we = 0; b2.size = 0; b2.is_unsigned = 0; b2.addr = 0; b2.wdata = 0;
      pc_we = 0; old_we = 0; pc_in = 0; pc_we2 = 0; old_we2 = 0; pc_in2 = 0;
      tick(); tick();
      checks++; if (a1.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", a1.ready); end
      checks++; if (a1.rvalid !== 1'b0 || a1.err !== 1'b0) begin errors++; $display("FAIL reset_rvalid_err got %0b%0b want 00", a1.rvalid, a1.err); end
      checks++; if (a1.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", a1.rdata); end
      checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL reset_pc got %h want 00000100", pc_out); end
      checks++; if (old_pc_out !== 32'h0) begin errors++; $display("FAIL reset_old_pc got %h want 0", old_pc_out); end
      checks++; if (b1.ready !== 1'b0 || pc_out2 !== 32'h0 || old_pc_out2 !== 32'h0) begin errors++; $display("FAIL reset_dut2 got ready %0b pc %h old %h want 0", b1.ready, pc_out2, old_pc_out2); end
      rst1 = 1'b0; rst2 = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 1100 && cnt == 0; k++) begin
         tick();
         if (k == 1) begin
            checks++; if (b1.ready !== 1'b1) begin errors++; $display("FAIL noclear_ready got %0b want 1", b1.ready); end
         end
         if (a1.ready === 1'b1) cnt = k;
      end
      checks++; if (cnt != 1024) begin errors++; $display("FAIL clear_cycles got %0d want 1024", cnt); end
   endtask

   task automatic test_cleared();
      drv1(1, 0, 2'b10, 0, 13'h000, 0); tick();
      checks++; if (a1.rvalid !== 1'b1 || a1.rdata !== 32'h0 || a1.err !== 1'b0) begin errors++; $display("FAIL cleared_w0 got v%0b %h e%0b want v1 0 e0", a1.rvalid, a1.rdata, a1.err); end
      drv1(1, 0, 2'b10, 0, 13'hFFC, 0); tick();
      checks++; if (a1.rvalid !== 1'b1 || a1.rdata !== 32'h0) begin errors++; $display("FAIL cleared_last got v%0b %h want v1 0", a1.rvalid, a1.rdata); end
      drv1(0, 0, 0, 0, 0, 0); tick();
   endtask

   task automatic test_store_load();
      drv1(1, 1, 2'b10, 0, 13'h400, 32'hDEADBEEF); tick();
      checks++; if (a1.rvalid !== 1'b1 || a1.rdata !== 32'h0 || a1.err !== 1'b0) begin errors++; $display("FAIL store_resp got v%0b %h e%0b want v1 0 e0", a1.rvalid, a1.rdata, a1.err); end
      drv1(0, 0, 0, 0, 0, 0);
      drv2(1, 0, 2'b00, 0, 13'h401, 0); tick();
      checks++; if (a1.rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %0b want 0", a1.rvalid); end
      checks++; if (a2.rvalid !== 1'b1 || a2.rdata !== 32'hFFFFFFBE) begin errors++; $display("FAIL byte_signed got v%0b %h want v1 ffffffbe", a2.rvalid, a2.rdata); end
      drv2(1, 0, 2'b00, 1, 13'h401, 0); tick();
      checks++; if (a2.rdata !== 32'h000000BE) begin errors++; $display("FAIL byte_unsigned got %h want 000000be", a2.rdata); end
      drv2(1, 0, 2'b01, 0, 13'h402, 0); tick();
      checks++; if (a2.rdata !== 32'hFFFFDEAD) begin errors++; $display("FAIL half_signed got %h want ffffdead", a2.rdata); end
      drv2(1, 0, 2'b10, 0, 13'h400, 0); tick();
      checks++; if (a2.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load got %h want deadbeef", a2.rdata); end
      drv2(0, 0, 0, 0, 0, 0); tick();
      checks++; if (a2.rvalid !== 1'b0) begin errors++; $display("FAIL p2_idle got %0b want 0", a2.rvalid); end
   endtask

   task automatic test_collision();
      drv1(1, 1, 2'b10, 0, 13'h400, 32'h0); tick();
      drv1(1, 1, 2'b01, 0, 13'h402, 32'h00001234);
      drv2(1, 1, 2'b00, 0, 13'h403, 32'h000000AA); tick();
      checks++; if (a1.rvalid !== 1'b1 || a2.rvalid !== 1'b1 || a1.err !== 1'b0 || a2.err !== 1'b0) begin errors++; $display("FAIL coll_resp got v%0b%0b e%0b%0b want v11 e00", a1.rvalid, a2.rvalid, a1.err, a2.err); end
      drv1(0, 0, 0, 0, 0, 0);
      drv2(1, 0, 2'b10, 0, 13'h400, 0); tick();
      checks++; if (a2.rdata !== 32'hAA340000) begin errors++; $display("FAIL coll_overlap got %h want aa340000", a2.rdata); end
      drv1(1, 1, 2'b00, 0, 13'h408, 32'h00000011);
      drv2(1, 1, 2'b00, 0, 13'h409, 32'h00000022); tick();
      drv1(1, 0, 2'b10, 0, 13'h408, 0); drv2(0, 0, 0, 0, 0, 0); tick();
      checks++; if (a1.rdata !== 32'h00002211) begin errors++; $display("FAIL coll_disjoint got %h want 00002211", a1.rdata); end
      drv1(1, 1, 2'b10, 0, 13'h40C, 32'h55667788);
      drv2(1, 0, 2'b10, 0, 13'h40C, 0); tick();
      checks++; if (a2.rvalid !== 1'b1 || a2.rdata !== 32'h0) begin errors++; $display("FAIL read_first got v%0b %h want v1 0", a2.rvalid, a2.rdata); end
      drv1(1, 0, 2'b10, 0, 13'h40C, 0); drv2(0, 0, 0, 0, 0, 0); tick();
      checks++; if (a1.rdata !== 32'h55667788) begin errors++; $display("FAIL after_write got %h want 55667788", a1.rdata); end
      drv1(0, 0, 0, 0, 0, 0); tick();
   endtask

   task automatic test_errors();
      logic [12:0] ad [6] = '{13'h002, 13'h001, 13'h010, 13'h1000, 13'h40C, 13'h40E};
      logic [1:0]  sz [6] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
      logic        we [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         drv1(1, we[i], sz[i], 0, ad[i], 32'h1234FFFF); tick();
         checks++; if (a1.rvalid !== 1'b1 || a1.err !== 1'b1 || a1.rdata !== 32'h0) begin errors++; $display("FAIL err_case%0d got v%0b e%0b %h want v1 e1 0", i, a1.rvalid, a1.err, a1.rdata); end
      end
      drv1(1, 0, 2'b10, 0, 13'h010, 0); tick();
      checks++; if (a1.err !== 1'b0 || a1.rdata !== 32'h0) begin errors++; $display("FAIL imem_unchanged got e%0b %h want e0 0", a1.err, a1.rdata); end
      drv1(1, 0, 2'b10, 0, 13'h40C, 0); tick();
      checks++; if (a1.err !== 1'b0 || a1.rdata !== 32'h55667788) begin errors++; $display("FAIL dmem_unchanged got e%0b %h want e0 55667788", a1.err, a1.rdata); end
      drv1(1, 0, 2'b01, 1, 13'h40E, 0); tick();
      checks++; if (a1.err !== 1'b0 || a1.rdata !== 32'h00005566) begin errors++; $display("FAIL half_unsigned got e%0b %h want e0 00005566", a1.err, a1.rdata); end
      drv1(0, 0, 0, 0, 0, 0); tick();
   endtask

   task automatic test_pc();
      pc_in = 32'h10; pc_we = 1; tick(); pc_we = 0;
      checks++; if (pc_out !== 32'h10 || old_pc_out !== 32'h0) begin errors++; $display("FAIL pc_load got %h/%h want 10/0", pc_out, old_pc_out); end
      pc_in = 32'h14; pc_we = 1; old_we = 1; tick(); pc_we = 0; old_we = 0;
      checks++; if (pc_out !== 32'h14 || old_pc_out !== 32'h10) begin errors++; $display("FAIL pc_both got %h/%h want 14/10", pc_out, old_pc_out); end
      pc_in = 32'h99; tick();
      checks++; if (pc_out !== 32'h14 || old_pc_out !== 32'h10) begin errors++; $display("FAIL pc_hold got %h/%h want 14/10", pc_out, old_pc_out); end
      old_we = 1; tick(); old_we = 0;
      checks++; if (pc_out !== 32'h14 || old_pc_out !== 32'h14) begin errors++; $display("FAIL old_only got %h/%h want 14/14", pc_out, old_pc_out); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         drvb(1, 1, 2'b10, 0, 12'(12'h400 + 4 * i), 32'hA0000000 + 32'(i)); tick();
      end
      drvb(0, 0, 0, 0, 0, 0); tick(); tick(); tick();
      for (int c = 0; c < 11; c++) begin
         if (c < 8) drvb(1, 0, 2'b10, 0, 12'(12'h400 + 4 * c), 0);
         else drvb(0, 0, 0, 0, 0, 0);
         tick();
         checks++;
         if (b1.rvalid !== (c >= 1 && c <= 8)) begin errors++; $display("FAIL b2b_valid c%0d got %0b want %0b", c, b1.rvalid, (c >= 1 && c <= 8)); end
         else if (c >= 1 && c <= 8 && b1.rdata !== 32'hA0000000 + 32'(c - 1)) begin errors++; $display("FAIL b2b_data c%0d got %h want %h", c, b1.rdata, 32'hA0000000 + 32'(c - 1)); end
      end
      checks++; if (b2.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_p2_quiet got %0b want 0", b2.rvalid); end
   endtask

   task automatic test_reset_burst();
      int pulses;
      for (int c = 0; c < 4; c++) begin
         drvb(1, 0, 2'b10, 0, 12'(12'h400 + 4 * c), 0); tick();
      end
      checks++; if (b1.rvalid !== 1'b1 || b1.rdata !== 32'hA0000002) begin errors++; $display("FAIL burst_pre got v%0b %h want v1 a0000002", b1.rvalid, b1.rdata); end
      rst2 = 1'b1; drvb(0, 0, 0, 0, 0, 0); #1;
      pulses = 0;
      if (b1.rvalid === 1'b1) pulses++;
      tick(); tick(); rst2 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (b1.rvalid !== 1'b0) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL burst_rst_rvalid got %0d pulses want 0", pulses); end
      checks++; if (b1.ready !== 1'b1) begin errors++; $display("FAIL burst_rst_ready got %0b want 1", b1.ready); end
      drvb(1, 0, 2'b10, 0, 12'h40C, 0); tick(); drvb(0, 0, 0, 0, 0, 0); tick();
      checks++; if (b1.rvalid !== 1'b1 || b1.rdata !== 32'hA0000003) begin errors++; $display("FAIL ram_kept got v%0b %h want v1 a0000003", b1.rvalid, b1.rdata); end
   endtask

   task automatic test_clear_restart();
      int cnt;
      drv1(1, 1, 2'b10, 0, 13'h500, 32'hCAFEF00D); tick(); drv1(0, 0, 0, 0, 0, 0);
      rst1 = 1'b1; tick(); rst1 = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      checks++; if (a1.ready !== 1'b0) begin errors++; $display("FAIL midclear_ready got %0b want 0", a1.ready); end
      rst1 = 1'b1; tick(); rst1 = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 1100 && cnt == 0; k++) begin
         tick();
         if (a1.ready === 1'b1) cnt = k;
      end
      checks++; if (cnt != 1024) begin errors++; $display("FAIL restart_cycles got %0d want 1024", cnt); end
      drv1(1, 0, 2'b10, 0, 13'h500, 0); tick(); drv1(0, 0, 0, 0, 0, 0);
      checks++; if (a1.rvalid !== 1'b1 || a1.rdata !== 32'h0) begin errors++; $display("FAIL restart_zero got v%0b %h want v1 0", a1.rvalid, a1.rdata); end
   endtask

   initial begin
      test_reset();
      test_cleared();
      test_store_load();
      test_collision();
      test_errors();
      test_pc();
      test_back_to_back();
      test_reset_burst();
      test_clear_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got no completion want finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mem_subsystem.md
# mem_subsystem

Parametrised dual-port memory subsystem for the core: unified instruction+data RAM with two independent request/response ports, byte/halfword/word access with sign/zero extension, alignment and range checking, configurable read latency, and an optional post-reset memory-clear sequencer. It also holds the program counter and previous-PC registers. Sits between the control unit/ALU and storage, replacing the fixed word-only memory block.

## Interface
- WORD_W, 32, data word width (multiple of 8)
- INSTR_WORDS, 256, words in instruction region (word addresses 0..INSTR_WORDS-1)
- DATA_WORDS, 768, words in data region (follows instruction region)
- ADDR_W, 12, byte-address width; must cover (INSTR_WORDS+DATA_WORDS)*WORD_W/8
- READ_LAT, 1, request-to-response latency, 1 or 2
- IMEM_WRITABLE, 0, 1 = writes to instruction region allowed
- CLEAR_ON_RST, 1, 1 = zero whole RAM after reset release
- RESET_PC, 0, pc_out value on reset

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pN_valid  in  1  port N request valid (N = 1, 2)
- pN_ready  out  1  port N can accept a request
- pN_addr  in  ADDR_W  byte address
- pN_we  in  1  1 = store, 0 = load
- pN_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- pN_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- pN_wdata  in  WORD_W  store data, right-aligned
- pN_rvalid  out  1  response valid, one-cycle pulse
- pN_rdata  out  WORD_W  load data, extended; 0 for stores and errors
- pN_err  out  1  qualifies pN_rvalid: request rejected
- pc_WE  in  1  load pc from pc_in
- pc_in  in  WORD_W  next PC
- old_pc_WE  in  1  copy pc_out into old_pc_out
- pc_out  out  WORD_W  program counter
- old_pc_out  out  WORD_W  previous PC

## Operation
- Request accepted on a rising edge when pN_valid & pN_ready. Every accepted request yields exactly one pN_rvalid pulse, in order; ports independent.
- States: CLEAR, RUN. After rst release with CLEAR_ON_RST=1: CLEAR writes zero to word 0,1,..,DEPTH-1 one per cycle, pN_ready=0; after last word -> RUN. CLEAR_ON_RST=0: straight to RUN. In RUN pN_ready=1.
- Error (pN_err=1, no RAM write, rdata=0): half with addr[0]=1; word with addr[1:0]!=0; size=11; word address >= INSTR_WORDS+DATA_WORDS; store to instruction region when IMEM_WRITABLE=0.
- Stores: byte enables from size and addr[1:0]; wdata low byte/half replicated onto the selected lane(s); other bytes untouched.
- Loads: word selected by addr[ADDR_W-1:2], lane by addr[1:0], extended per pN_unsigned.
- Same-cycle collision, both ports storing to same word: per byte, port 2 wins where enables overlap; disjoint lanes both land.
- Load concurrent with any store (same or other port) to the same word returns pre-write data (read-first).
- pc and old_pc update only on their WE; both may assert in one cycle: old_pc_out gets pre-update pc_out.

## Timing
- Reset values: pN_rvalid=0, pN_rdata=0, pN_err=0, pN_ready=0, pc_out=RESET_PC, old_pc_out=0; FSM in CLEAR (or RUN if CLEAR_ON_RST=0, ready=1 first cycle after release).
- CLEAR lasts exactly DEPTH cycles; pN_ready rises the cycle after the last clear write.
- READ_LAT=1: rvalid/rdata/err registered, valid the cycle after acceptance. READ_LAT=2: one extra output register stage, fully pipelined; back-to-back requests give back-to-back responses.
- rst asserted mid-operation: in-flight responses discarded, no rvalid; mid-CLEAR reset restarts CLEAR from word 0. RAM contents not reset by rst itself.
- Stores visible to loads accepted on the following cycle.

## Test plan
- Reset with CLEAR_ON_RST=1, DEPTH=1024 -> pN_ready low 1024 cycles after release, then high; load any word returns 0.
- P1 store word 0xDEADBEEF at 0x400, P2 load byte addr 0x401 signed then unsigned -> 0xFFFFFFBE then 0x000000BE, each READ_LAT cycles after acceptance.
- P1 store half 0x1234 at 0x402 and P2 store byte 0xAA at 0x403 same cycle over 0x00000000 -> word reads 0xAA340000.
- P1 load word at 0x002, half at 0x001, store to 0x010 with IMEM_WRITABLE=0, address 0x1000 -> each pN_err=1, rdata=0, RAM unchanged.
- READ_LAT=2, 8 back-to-back P1 loads -> 8 consecutive rvalid pulses, in order, first 2 cycles after first acceptance; rst during burst -> no further rvalid.
- pc_WE and old_pc_WE together with pc_out=0x10, pc_in=0x14 -> next cycle pc_out=0x14, old_pc_out=0x10.
